// File: rtl/eth_dibit_depacketizer.sv
// eth_dibit_depacketizer
// Receive side of the Ethernet dibit link. Locks onto preamble + SFD, shifts in
// the 14-byte MAC header, filters on destination address (own MAC or broadcast),
// then streams payload bytes out one at a time. FCS bytes pass through unchecked.
module eth_dibit_depacketizer #(
  parameter logic [47:0] MY_MAC       = 48'hF00DDEADBEEF,
  parameter int          MIN_PREAMBLE = 8,
  parameter int          MAX_PAYLOAD  = 1504
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_axiiv,
  input  logic [1:0]  i_axiid,
  output logic        o_axiov,
  output logic [7:0]  o_axiod,
  output logic [15:0] o_ethertype,
  output logic [47:0] o_src_mac,
  output logic        o_frame_done,
  output logic        o_frame_err
);

  localparam int BCW = $clog2(MAX_PAYLOAD + 1);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    HEADER,
    DATA,
    OVERFLOW,
    DROP
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [5:0]       r_sr;
  logic [1:0]       r_dibitCnt;
  logic [7:0]       r_preCnt;
  logic [1:0]       r_sfdCnt;
  logic [3:0]       r_hdrIdx;
  logic [55:0]      r_hdr;
  logic [BCW-1:0]   r_byteCnt;
  logic             r_errFlag;

  logic [7:0]       w_byte;
  logic             w_byteDone;
  logic [47:0]      w_dest;
  logic             w_destOk;

  // The incoming dibit completes a byte when three earlier dibits are already held.
  assign w_byte     = {r_sr, i_axiid};
  assign w_byteDone = (r_dibitCnt == 2'd3);
  // r_hdr holds header bytes 0-4 when byte 5 arrives, so this is the full destination.
  assign w_dest     = {r_hdr[39:0], w_byte};
  assign w_destOk   = (w_dest == MY_MAC) || (w_dest == 48'hFFFFFFFFFFFF);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state logic: a low valid always ends whatever frame is in progress.
  always_comb begin
    w_nextState = r_state;
    if (!i_axiiv) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:
          if (i_axiid == 2'b01) w_nextState = PREAMBLE;
        PREAMBLE:
          if (i_axiid == 2'b11)
            w_nextState = (r_preCnt >= 8'(MIN_PREAMBLE)) ? SFD : DROP;
          else if (i_axiid != 2'b01)
            w_nextState = DROP;
        SFD:
          if (i_axiid != 2'b01)      w_nextState = DROP;
          else if (r_sfdCnt == 2'd2) w_nextState = HEADER;
        HEADER:
          if (w_byteDone) begin
            if (r_hdrIdx == 4'd5 && !w_destOk) w_nextState = DROP;
            else if (r_hdrIdx == 4'd13)        w_nextState = DATA;
          end
        DATA:
          if (w_byteDone && r_byteCnt == BCW'(MAX_PAYLOAD)) w_nextState = OVERFLOW;
        default: ;
      endcase
    end
  end

  // Datapath: counters, byte assembly, header capture and the registered output strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sr         <= '0;
      r_dibitCnt   <= '0;
      r_preCnt     <= '0;
      r_sfdCnt     <= '0;
      r_hdrIdx     <= '0;
      r_hdr        <= '0;
      r_byteCnt    <= '0;
      r_errFlag    <= 1'b0;
      o_axiov      <= 1'b0;
      o_axiod      <= '0;
      o_ethertype  <= '0;
      o_src_mac    <= '0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_axiov      <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
      if (!i_axiiv) begin
        r_dibitCnt <= '0;
        r_preCnt   <= '0;
        if (r_state == DATA || r_state == OVERFLOW) begin
          o_frame_done <= 1'b1;
          o_frame_err  <= r_errFlag | (r_dibitCnt != 2'd0);
        end
      end else begin
        case (r_state)
          IDLE:
            r_preCnt <= (i_axiid == 2'b01) ? 8'd1 : 8'd0;
          PREAMBLE: begin
            r_sfdCnt <= '0;
            if (i_axiid == 2'b01 && r_preCnt != 8'hFF) r_preCnt <= r_preCnt + 8'd1;
          end
          SFD: begin
            r_sfdCnt   <= r_sfdCnt + 2'd1;
            r_dibitCnt <= '0;
            r_hdrIdx   <= '0;
          end
          HEADER: begin
            r_sr       <= w_byte[5:0];
            r_dibitCnt <= r_dibitCnt + 2'd1;
            if (w_byteDone) begin
              r_hdr    <= {r_hdr[47:0], w_byte};
              r_hdrIdx <= r_hdrIdx + 4'd1;
              if (r_hdrIdx == 4'd13) begin
                o_src_mac   <= r_hdr[55:8];
                o_ethertype <= {r_hdr[7:0], w_byte};
                r_byteCnt   <= '0;
                r_errFlag   <= 1'b0;
              end
            end
          end
          DATA: begin
            r_sr       <= w_byte[5:0];
            r_dibitCnt <= r_dibitCnt + 2'd1;
            if (w_byteDone) begin
              if (r_byteCnt == BCW'(MAX_PAYLOAD)) begin
                r_errFlag <= 1'b1;
              end else begin
                o_axiov   <= 1'b1;
                o_axiod   <= w_byte;
                r_byteCnt <= r_byteCnt + BCW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
